// File: rtl/sr04_ctrl_pkg.sv
// Shared state encoding, error constants and averaging helper for the HC-SR04 controller.
package sr04_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_TRIG,
      ST_WAIT_ECHO,
      ST_MEASURE,
      ST_DIVIDE,
      ST_HOLDOFF
   } sr04_state_e;

   localparam logic [15:0] ERR_US    = 16'hFFFF;
   localparam logic [9:0]  ERR_CM    = 10'h3FF;
   localparam int          DIV_STEPS = 16;

   // Mean of four centimetre readings, truncated (sum >> 2).
   function automatic logic [9:0] avg4(input logic [9:0] a, input logic [9:0] b,
                                       input logic [9:0] c, input logic [9:0] d);
      logic [11:0] s;
      s = 12'(a) + 12'(b) + 12'(c) + 12'(d);
      return s[11:2];
   endfunction

endpackage

// File: rtl/sr04_ctrl_div.sv
// Restoring divider: 16-bit dividend by a constant divisor, 10-bit quotient,
// fixed 16-cycle latency counted from the start cycle; start is ignored while busy.
module sr04_div
   import sr04_ctrl_pkg::*;
#(
   parameter int DIVISOR = 58
) (
   input  logic        clk_1m,
   input  logic        rst_n,
   input  logic [15:0] dividend_i,
   input  logic        start_i,
   output logic [9:0]  quot_o,
   output logic        done_o
);

   localparam logic [16:0] DIV17 = 17'(DIVISOR);

   logic [15:0] rem_q, rem_d;
   logic [15:0] dvd_q, dvd_src;
   logic [9:0]  quo_q, quo_d;
   logic [3:0]  cnt_q;
   logic        busy_q;
   logic        done_q;
   logic [16:0] trial;
   logic        qbit;

   // The first step runs on the start edge straight from the input operand.
   always_comb begin
      dvd_src = busy_q ? dvd_q : dividend_i;
      trial   = {1'b0, (busy_q ? rem_q : 16'd0)} << 1;
      trial[0] = dvd_src[15];
      qbit    = 1'b0;
      rem_d   = trial[15:0];
      if (trial >= DIV17) begin
         qbit  = 1'b1;
         rem_d = 16'(trial - DIV17);
      end
      quo_d = {(busy_q ? quo_q[8:0] : 9'd0), qbit};
   end

   always_ff @(posedge clk_1m or negedge rst_n) begin
      if (!rst_n) begin
         rem_q  <= '0;
         dvd_q  <= '0;
         quo_q  <= '0;
         cnt_q  <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (busy_q) begin
            rem_q <= rem_d;
            dvd_q <= {dvd_src[14:0], 1'b0};
            quo_q <= quo_d;
            cnt_q <= cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
               busy_q <= 1'b0;
               done_q <= 1'b1;
            end
         end else if (start_i) begin
            rem_q  <= rem_d;
            dvd_q  <= {dvd_src[14:0], 1'b0};
            quo_q  <= quo_d;
            cnt_q  <= 4'(DIV_STEPS - 1);
            busy_q <= 1'b1;
         end
      end
   end

   assign quot_o = quo_q;
   assign done_o = done_q;

endmodule

// File: rtl/sr04_ctrl.sv
// HC-SR04 ranging controller: periodic trigger, echo width in us and distance in cm.
// Build option SR04_AVG_EN reports the mean of the last four good readings in dist_cm.
module sr04_ctrl
   import sr04_ctrl_pkg::*;
#(
   parameter int TRIG_US    = 10,
   parameter int PERIOD_US  = 60000,
   parameter int TIMEOUT_US = 30000,
   parameter int CM_DIV     = 58
) (
   input  logic        clk_1m,
   input  logic        rst_n,
   input  logic        enable,
   input  logic        s1_echo,
   output logic        s1_trig,
   output logic [15:0] dist_us,
   output logic [9:0]  dist_cm,
   output logic        dist_vld,
   output logic        dist_err,
   output logic        busy
);

   localparam int                PER_W     = $clog2(PERIOD_US);
   localparam logic [PER_W-1:0]  PER_MAX   = PER_W'(PERIOD_US - 1);
   localparam logic [15:0]       TRIG_LAST = 16'(TRIG_US - 1);
   localparam logic [15:0]       WAIT_LAST = 16'(TIMEOUT_US - 1);
   localparam logic [15:0]       WIDTH_MAX = 16'(TIMEOUT_US);

   sr04_state_e      state_q;
   logic [PER_W-1:0] per_q;
   logic [15:0]      cnt_q;
   logic             trig_q;
   logic [15:0]      dist_us_q;
   logic [9:0]       dist_cm_q;
   logic             vld_q;
   logic             err_q;
   logic             echo_m_q, echo_s_q, echo_p_q;
   logic             echo_rise, echo_fall;
   logic             div_start, div_done;
   logic [9:0]       div_quot;

`ifdef SR04_AVG_EN
   logic [3:0][9:0]  win_q;
   logic             primed_q;
   logic             avg_pend_q;
`endif

   always_ff @(posedge clk_1m or negedge rst_n) begin
      if (!rst_n) {echo_m_q, echo_s_q, echo_p_q} <= '0;
      else        {echo_m_q, echo_s_q, echo_p_q} <= {s1_echo, echo_m_q, echo_s_q};
   end

   assign echo_rise = echo_s_q & ~echo_p_q;
   assign echo_fall = ~echo_s_q & echo_p_q;
   // A fall on the very cycle the width hits the limit is an error, so no divide.
   assign div_start = (state_q == ST_MEASURE) && echo_fall && (cnt_q < WIDTH_MAX);

   sr04_div #(
      .DIVISOR(CM_DIV)
   ) u_div (
      .clk_1m    (clk_1m),
      .rst_n     (rst_n),
      .dividend_i(cnt_q),
      .start_i   (div_start),
      .quot_o    (div_quot),
      .done_o    (div_done)
   );

   // cnt_q is shared: trigger width in TRIG, wait time in WAIT_ECHO, echo width in MEASURE.
   always_ff @(posedge clk_1m or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         per_q      <= '0;
         cnt_q      <= '0;
         trig_q     <= 1'b0;
         dist_us_q  <= ERR_US;
         dist_cm_q  <= ERR_CM;
         vld_q      <= 1'b0;
         err_q      <= 1'b0;
`ifdef SR04_AVG_EN
         win_q      <= '0;
         primed_q   <= 1'b0;
         avg_pend_q <= 1'b0;
`endif
      end else begin
         vld_q <= 1'b0;
         if (per_q != PER_MAX) per_q <= per_q + PER_W'(1);
         case (state_q)
            ST_IDLE: begin
               if (enable) begin
                  state_q <= ST_TRIG;
                  trig_q  <= 1'b1;
                  per_q   <= '0;
                  cnt_q   <= '0;
               end
            end
            ST_TRIG: begin
               if (cnt_q == TRIG_LAST) begin
                  state_q <= ST_WAIT_ECHO;
                  trig_q  <= 1'b0;
                  cnt_q   <= '0;
               end else begin
                  cnt_q <= cnt_q + 16'd1;
               end
            end
            ST_WAIT_ECHO: begin
               if (echo_rise) begin
                  state_q <= ST_MEASURE;
                  cnt_q   <= 16'd1;
               end else if (cnt_q == WAIT_LAST) begin
                  state_q   <= ST_HOLDOFF;
                  dist_us_q <= ERR_US;
                  dist_cm_q <= ERR_CM;
                  err_q     <= 1'b1;
                  vld_q     <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + 16'd1;
               end
            end
            ST_MEASURE: begin
               if (cnt_q >= WIDTH_MAX) begin
                  state_q   <= ST_HOLDOFF;
                  dist_us_q <= ERR_US;
                  dist_cm_q <= ERR_CM;
                  err_q     <= 1'b1;
                  vld_q     <= 1'b1;
               end else if (echo_fall) begin
                  state_q   <= ST_DIVIDE;
                  dist_us_q <= cnt_q;
               end else begin
                  cnt_q <= cnt_q + 16'd1;
               end
            end
            ST_DIVIDE: begin
`ifdef SR04_AVG_EN
               // The first good reading fills the whole window so the mean starts sane.
               if (div_done) begin
                  avg_pend_q <= 1'b1;
                  primed_q   <= 1'b1;
                  if (primed_q) win_q <= {win_q[2:0], div_quot};
                  else          win_q <= {4{div_quot}};
               end else if (avg_pend_q) begin
                  avg_pend_q <= 1'b0;
                  state_q    <= ST_HOLDOFF;
                  dist_cm_q  <= avg4(win_q[0], win_q[1], win_q[2], win_q[3]);
                  err_q      <= 1'b0;
                  vld_q      <= 1'b1;
               end
`else
               if (div_done) begin
                  state_q   <= ST_HOLDOFF;
                  dist_cm_q <= div_quot;
                  err_q     <= 1'b0;
                  vld_q     <= 1'b1;
               end
`endif
            end
            ST_HOLDOFF: begin
               if (per_q == PER_MAX) begin
                  if (enable) begin
                     state_q <= ST_TRIG;
                     trig_q  <= 1'b1;
                     per_q   <= '0;
                     cnt_q   <= '0;
                  end else begin
                     state_q <= ST_IDLE;
                  end
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign s1_trig  = trig_q;
   assign dist_us  = dist_us_q;
   assign dist_cm  = dist_cm_q;
   assign dist_vld = vld_q;
   assign dist_err = err_q;
   assign busy     = (state_q != ST_IDLE);

endmodule
